// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel counters, registered active-low syncs, blanking qualifier.
// Define VGA_SYNC_CLKDIV_EN to derive the pixel enable by dividing clk by 2 internally.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_end
);

  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] h_q, v_q;
  logic [9:0] h_next, v_next;

`ifdef VGA_SYNC_CLKDIV_EN
  logic phase;

  always_ff @(posedge clk) begin
    if (reset) phase <= 1'b0;
    else       phase <= ~phase;
  end

  assign p_tick = phase;
`else
  assign p_tick = 1'b1;
`endif

  always_comb begin
    h_next = h_q;
    v_next = v_q;
    if (p_tick) begin
      if (h_q == H_MAX) begin
        h_next = '0;
        v_next = (v_q == V_MAX) ? '0 : v_q + 10'd1;
      end else begin
        h_next = h_q + 10'd1;
      end
    end
  end

  // Syncs decode the next counts so they change on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      h_q   <= h_next;
      v_q   <= v_next;
      hsync <= !((h_next >= HS_START) && (h_next <= HS_END));
      vsync <= !((v_next >= VS_START) && (v_next <= VS_END));
    end
  end

  assign HCount    = h_q;
  assign VCount    = v_q;
  assign video_on  = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_end = p_tick && (h_q == H_MAX) && (v_q == V_MAX);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance for line checks, reduced-timing instance for frame checks.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_CLKDIV_EN
  localparam int unsigned DIV = 2;
`else
  localparam int unsigned DIV = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [9:0] a_h, a_v, b_h, b_v;
  logic       a_hs, a_vs, a_von, a_pt, a_fe;
  logic       b_hs, b_vs, b_von, b_pt, b_fe;

  vga_sync_gen dut (
    .clk(clk), .reset(rst_a), .HCount(a_h), .VCount(a_v), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_von), .p_tick(a_pt), .frame_end(a_fe)
  );

  // Small raster: 16 x 12, hsync low at h 10..12, vsync low at v 8..9, visible 8 x 6.
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clk(clk), .reset(rst_b), .HCount(b_h), .VCount(b_v), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .p_tick(b_pt), .frame_end(b_fe)
  );

  typedef struct {
    int unsigned ticks;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        von;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold_reset_a();
    rst_a = 1'b1; step(3);
    chk("reset_a", {a_h, a_v, a_hs, a_vs, a_von, a_fe}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    rst_a = 1'b0;
  endtask

  task automatic hold_reset_b();
    rst_b = 1'b1; step(3);
    chk("reset_b", {b_h, b_v, b_hs, b_vs, b_von, b_fe}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    rst_b = 1'b0;
  endtask

  initial begin
    int unsigned t;
    int unsigned mh, mv, errs, lows, fes;
    logic mpt, ehs, evs, evon, efe;

    vecs[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{10,   10'd10,  10'd0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{640,  10'd640, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{655,  10'd655, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{656,  10'd656, 10'd0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{751,  10'd751, 10'd0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{752,  10'd752, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{799,  10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1439, 10'd639, 10'd1, 1'b1, 1'b1, 1'b1};

    // Default timing: directed positions along the first two lines.
    hold_reset_a();
    t = 0;
    foreach (vecs[i]) begin
      step((vecs[i].ticks - t) * DIV);
      t = vecs[i].ticks;
      chk($sformatf("vec%0d_t%0d", i, vecs[i].ticks), {a_h, a_v, a_hs, a_vs, a_von},
          {vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].von});
    end

    // Default timing: one full line against a reference model.
    hold_reset_a();
    mh = 0; mv = 0; errs = 0; lows = 0; mpt = (DIV == 1);
    repeat (800 * DIV) begin
      ehs  = !(mh >= 656 && mh <= 751);
      evon = (mh < 640) && (mv < 480);
      if ({a_h, a_v, a_hs, a_vs, a_von, a_pt} !== {10'(mh), 10'(mv), ehs, 1'b1, evon, mpt}) errs++;
      if (mpt) begin
        if (!a_hs) lows++;
        if (mh == 799) begin mh = 0; mv++; end else mh++;
      end
      if (DIV == 2) mpt = ~mpt;
      step(1);
    end
    chk("line_scan_errs", errs, 0);
    chk("hsync_low_ticks", lows, 96);
    chk("line_end_pos", {a_h, a_v}, {10'd0, 10'd1});

    // Reduced timing: whole frame against a reference model.
    hold_reset_b();
    mh = 0; mv = 0; errs = 0; lows = 0; fes = 0; mpt = (DIV == 1);
    repeat (192 * DIV) begin
      ehs  = !(mh >= 10 && mh <= 12);
      evs  = !(mv >= 8 && mv <= 9);
      evon = (mh < 8) && (mv < 6);
      efe  = mpt && (mh == 15) && (mv == 11);
      if ({b_h, b_v, b_hs, b_vs, b_von, b_pt, b_fe} !==
          {10'(mh), 10'(mv), ehs, evs, evon, mpt, efe}) errs++;
      if (b_fe) begin
        fes++;
        chk("frame_end_pos", {b_h, b_v}, {10'd15, 10'd11});
      end
      if (mpt) begin
        if (!b_vs) lows++;
        if (mh == 15) begin
          mh = 0;
          mv = (mv == 11) ? 0 : mv + 1;
        end else mh++;
      end
      if (DIV == 2) mpt = ~mpt;
      step(1);
    end
    chk("frame_scan_errs", errs, 0);
    chk("vsync_low_ticks", lows, 32);
    chk("frame_end_count", fes, 1);
    chk("frame_wrap_pos", {b_h, b_v, b_hs, b_vs, b_von}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});

    // Reduced timing: mid-frame reset at (5,4), then timing restarts from the origin.
    hold_reset_b();
    step(69 * DIV);
    chk("pre_midreset_pos", {b_h, b_v}, {10'd5, 10'd4});
    rst_b = 1'b1; step(1); rst_b = 1'b0;
    chk("midreset_state", {b_h, b_v, b_hs, b_vs, b_von, b_fe},
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    step(69 * DIV);
    chk("post_midreset_pos", {b_h, b_v, b_hs, b_vs, b_von}, {10'd5, 10'd4, 1'b1, 1'b1, 1'b1});
    step(5 * DIV);
    chk("post_midreset_hsync", {b_h, b_v, b_hs, b_von}, {10'd10, 10'd4, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA display path: produces the 10-bit `HCount`/`VCount` pixel coordinates consumed by the text and graphics overlay blocks, plus the `hsync`/`vsync` pulses and the `video_on` blanking qualifier for the monitor. Default timing is 640x480 @ 60 Hz (800 x 525 total) from a 25 MHz pixel rate, optionally derived internally from the 50 MHz board clock. Overlay blocks decode `HCount`/`VCount` combinationally and their `rgb` is gated by `video_on` downstream.

## Interface
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `clk`  in  1  board clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `HCount`  out  10  current pixel column, 0..H_TOTAL-1
- `VCount`  out  10  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `video_on`  out  1  high while inside the visible area
- `p_tick`  out  1  pixel-rate enable; counters advance only when high
- `frame_end`  out  1  single-`clk` pulse on the last pixel of a frame

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must be ≤1024; 10-bit unsigned arithmetic, no other width extension.
- Horizontal counter: on a `clk` edge with `p_tick`=1, `HCount` increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on the same edge that wraps `HCount`; at V_TOTAL-1 it wraps to 0. Simultaneous wrap of both → (0,0).
- `hsync`=0 iff H_DISPLAY+H_FRONT ≤ `HCount` ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
- `vsync`=0 iff V_DISPLAY+V_FRONT ≤ `VCount` ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- `video_on`=1 iff `HCount`<H_DISPLAY and `VCount`<V_DISPLAY.
- `hsync`/`vsync` are registers loaded from the next-count decode, so they are glitch-free and cycle-aligned with the registered counters. `video_on` may be a decode of the registered counters.
- `frame_end` = `p_tick` & (`HCount`=H_TOTAL-1) & (`VCount`=V_TOTAL-1).

## Timing
- Reset (any cycle `reset`=1, including mid-frame): next edge sets `HCount`=0, `VCount`=0, `hsync`=1, `vsync`=1, divider phase=0. Hence `video_on`=1, `frame_end`=0. Reset overrides `p_tick`.
- Counter outputs change only on `clk` edges where `p_tick`=1; all decoded outputs are valid in the same cycle as the counts.
- Line period = H_TOTAL pixel ticks; frame period = H_TOTAL*V_TOTAL ticks (420 000).
- No handshake: consumers sample coordinates combinationally and must register their results on `p_tick`.

## Configuration
- `VGA_SYNC_CLKDIV_EN` defined: internal divide-by-2. The phase register resets to 0 and toggles every `clk`; `p_tick` = phase. The first `p_tick`=1 occurs on the first cycle after `reset` deasserts, then every other cycle. For the 50 MHz `clk`.
- Not defined: `p_tick` tied to 1 and counters advance every `clk`. For a 25 MHz `clk` from a DCM.

## Test plan
- Reset: hold `reset` 3 cycles → `HCount`=0, `VCount`=0, `hsync`=1, `vsync`=1, `video_on`=1, `frame_end`=0.
- Hsync: run one line → `hsync` low exactly for `HCount` 656..751 (96 ticks); `video_on` falls at `HCount`=640; `VCount` increments when `HCount` 799→0.
- Vsync/wrap: run a full frame → `vsync` low for `VCount` 490..491 only (1600 ticks); `frame_end` pulses once at (799,524); next tick gives (0,0).
- Mid-frame reset: assert `reset` at (300,200) for 1 cycle → next edge (0,0), `hsync`=1; timing then repeats from the start.
- With `VGA_SYNC_CLKDIV_EN`: `p_tick` alternates 1,0,… from the first post-reset cycle; `HCount` reaches 10 after 20 `clk` cycles and frame period = 840 000 `clk`.
- Without the macro: `HCount` reaches 10 after 10 `clk` cycles and frame period = 420 000 `clk`.
